// File: rtl/dhp_sync_gen.sv
// DHP-side timing master for the DCD readout link: row strobe (R2S) every row,
// frame strobe (FSYNC) on row 0, with graceful stop and frame counting.
module dhp_sync_gen #(
    parameter int ROW_W = 16,
    parameter int RPF_W = 10,
    parameter int FRM_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [ROW_W-1:0] i_row_period,
    input  logic [3:0]       i_r2s_width,
    input  logic [RPF_W-1:0] i_rows_per_frame,
    input  logic [FRM_W-1:0] i_num_frames,
    output logic             o_r2s,
    output logic             o_fsync,
    output logic [RPF_W-1:0] o_row_num,
    output logic [FRM_W-1:0] o_frame_cnt,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [ROW_W-1:0] r_phase, w_phase_nxt;
    logic [RPF_W-1:0] r_row, w_row_nxt;
    logic [FRM_W-1:0] r_frame, w_frame_nxt;
    logic             r_stop_pend, w_stop_pend_nxt;
    logic [ROW_W-1:0] r_period, w_period_nxt;
    logic [ROW_W-1:0] r_width, w_width_nxt;
    logic [RPF_W-1:0] r_rows, w_rows_nxt;
    logic [FRM_W-1:0] r_nframes, w_nframes_nxt;
    logic             r_r2s, w_r2s_nxt;
    logic             r_fsync, w_fsync_nxt;
    logic             r_done, w_done_nxt;

    // Effective (clamped) configuration, latched only at START
    logic [ROW_W-1:0] w_period_cl, w_width_raw, w_width_cl;
    logic [RPF_W-1:0] w_rows_cl;

    assign w_period_cl = (i_row_period < ROW_W'(2)) ? ROW_W'(2) : i_row_period;
    assign w_width_raw = (i_r2s_width == 4'd0) ? ROW_W'(1) : ROW_W'(i_r2s_width);
    assign w_width_cl  = (w_width_raw > (w_period_cl - ROW_W'(1))) ?
                         (w_period_cl - ROW_W'(1)) : w_width_raw;
    assign w_rows_cl   = (i_rows_per_frame == '0) ? RPF_W'(1) : i_rows_per_frame;

    logic             w_last_phase, w_last_row, w_eof, w_stop_any, w_finish;
    logic [FRM_W-1:0] w_frame_inc;

    assign w_last_phase = (r_phase == (r_period - ROW_W'(1)));
    assign w_last_row   = (r_row == (r_rows - RPF_W'(1)));
    assign w_eof        = w_last_phase && w_last_row;
    assign w_frame_inc  = r_frame + FRM_W'(1);
    assign w_stop_any   = r_stop_pend | i_stop;
    assign w_finish     = w_eof && (((r_nframes != '0) && (w_frame_inc == r_nframes)) || w_stop_any);

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_row_nxt       = r_row;
        w_frame_nxt     = r_frame;
        w_stop_pend_nxt = r_stop_pend;
        w_period_nxt    = r_period;
        w_width_nxt     = r_width;
        w_rows_nxt      = r_rows;
        w_nframes_nxt   = r_nframes;
        w_r2s_nxt       = 1'b0;
        w_fsync_nxt     = 1'b0;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nxt     = ST_RUN;
                    w_phase_nxt     = '0;
                    w_row_nxt       = '0;
                    w_frame_nxt     = '0;
                    w_stop_pend_nxt = 1'b0;
                    w_period_nxt    = w_period_cl;
                    w_width_nxt     = w_width_cl;
                    w_rows_nxt      = w_rows_cl;
                    w_nframes_nxt   = i_num_frames;
                    w_r2s_nxt       = 1'b1;
                    w_fsync_nxt     = 1'b1;
                end
            end
            ST_RUN: begin
                w_stop_pend_nxt = w_stop_any;
                if (w_finish) begin
                    // Row index is left on the last row so it can be read back in IDLE
                    w_state_nxt     = ST_IDLE;
                    w_frame_nxt     = w_frame_inc;
                    w_stop_pend_nxt = 1'b0;
                    w_phase_nxt     = '0;
                    w_done_nxt      = 1'b1;
                end else begin
                    w_phase_nxt = w_last_phase ? '0 : r_phase + ROW_W'(1);
                    if (w_last_phase)
                        w_row_nxt = w_last_row ? '0 : r_row + RPF_W'(1);
                    if (w_eof)
                        w_frame_nxt = w_frame_inc;
                    w_r2s_nxt   = (w_phase_nxt < r_width);
                    w_fsync_nxt = w_r2s_nxt && (w_row_nxt == '0);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_row       <= '0;
            r_frame     <= '0;
            r_stop_pend <= 1'b0;
            r_period    <= ROW_W'(2);
            r_width     <= ROW_W'(1);
            r_rows      <= RPF_W'(1);
            r_nframes   <= '0;
            r_r2s       <= 1'b0;
            r_fsync     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_row       <= w_row_nxt;
            r_frame     <= w_frame_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_period    <= w_period_nxt;
            r_width     <= w_width_nxt;
            r_rows      <= w_rows_nxt;
            r_nframes   <= w_nframes_nxt;
            r_r2s       <= w_r2s_nxt;
            r_fsync     <= w_fsync_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign o_r2s       = r_r2s;
    assign o_fsync     = r_fsync;
    assign o_row_num   = r_row;
    assign o_frame_cnt = r_frame;
    assign o_busy      = (r_state == ST_RUN);
    assign o_done      = r_done;

endmodule
